stack_pointer_unit: RTL and testbench

- Parametrised, multi-bank successor to the single 16-bit stack pointer.
- Holds NUM_BANKS independent downward-growing stack pointers, for example user and interrupt stacks, selected per cycle.
- Adds bound checking against a fixed stack window, signed frame adjust, sticky overflow/underflow flags and a global fault state machine.
- Sits in the execute stage. sp_out feeds the ALU mux and the memory address select.

---
 rtl/stack_pointer_pkg.sv | 27 ++
 rtl/stack_bound_check.sv | 70 +++++++
 rtl/stack_pointer_unit.sv | 191 +++++++++++++++++++
 tb/tb_stack_pointer_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pointer_pkg.sv
// Shared types for the multi-bank stack pointer unit.
//   state_e : global fault FSM states.
//   op_e    : per-cycle operation after priority resolution (first match wins).
//   sel_width() : width of the bank select bus for a given bank count.
package stack_pointer_pkg;

    typedef enum logic [0:0] {
        RUN,
        FAULT
    } state_e;

    typedef enum logic [2:0] {
        OP_LOADPOP,
        OP_HOLDPP,
        OP_LOAD,
        OP_POP,
        OP_PUSH,
        OP_ADJ,
        OP_NONE
    } op_e;

    // A single bank still needs a 1-bit select so the port never collapses to zero width.
    function automatic int unsigned sel_width(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/stack_bound_check.sv
// Combinational next-SP computation and bound checking for one stack pointer.
//   sp      : current SP of the selected bank
//   op      : resolved operation for this cycle
//   adj_val : signed frame adjust (positive frees stack)
//   sp_in   : load value
//   sp_next : SP to write back (equals sp when an event holds it)
//   ovf_evt : push at full depth, or adjust past MAX_DEPTH
//   unf_evt : pop at empty, or adjust below empty
module stack_bound_check
    import stack_pointer_pkg::*;
#(
    parameter int unsigned      AW        = 16,
    parameter logic [AW-1:0]    STACK_TOP = '0,
    parameter int unsigned      MAX_DEPTH = 256
) (
    input  logic [AW-1:0] sp,
    input  op_e           op,
    input  logic [AW-1:0] adj_val,
    input  logic [AW-1:0] sp_in,
    output logic [AW-1:0] sp_next,
    output logic          ovf_evt,
    output logic          unf_evt
);

    localparam logic [AW-1:0] MaxDepth = AW'(MAX_DEPTH);

    logic [AW-1:0]        depth;
    logic signed [AW+1:0] depth_adj;

    assign depth = STACK_TOP - sp;

    // Two extra bits hold the full range of an unsigned depth minus a signed adjust.
    assign depth_adj = $signed({2'b00, depth}) - $signed({{2{adj_val[AW-1]}}, adj_val});

    always_comb begin
        sp_next = sp;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case (op)
            OP_LOADPOP: sp_next = sp_in + 1'b1;
            OP_HOLDPP:  sp_next = sp;
            OP_LOAD:    sp_next = sp_in;
            OP_POP: begin
                if (depth == '0) begin
                    unf_evt = 1'b1;
                end else begin
                    sp_next = sp + 1'b1;
                end
            end
            OP_PUSH: begin
                if (depth == MaxDepth) begin
                    ovf_evt = 1'b1;
                end else begin
                    sp_next = sp - 1'b1;
                end
            end
            OP_ADJ: begin
                if (depth_adj[AW+1]) begin
                    unf_evt = 1'b1;
                end else if (depth_adj > $signed({2'b00, MaxDepth})) begin
                    ovf_evt = 1'b1;
                end else begin
                    sp_next = sp + adj_val;
                end
            end
            default: sp_next = sp;
        endcase
    end

endmodule

// File: rtl/stack_pointer_unit.sv
// Multi-bank downward-growing stack pointer unit for the execute stage.
//   clk, rst   : clock, asynchronous active-high reset
//   bank_sel   : bank addressed this cycle
//   push/pop/load/adj_en, adj_val, sp_in : SP operations (priority resolved here)
//   fault_clr  : leave FAULT and clear sticky flags
//   sp_out     : effective address this cycle (combinational)
//   sp_q/depth : registered SP of the selected bank and its depth
//   op_err     : current push/pop/adjust is illegal; memory write must be blocked
//   overflow/underflow : sticky event flags
//   fault, fault_bank  : FSM in FAULT, bank that caused the last fault
module stack_pointer_unit
    import stack_pointer_pkg::*;
#(
    parameter int unsigned      AW        = 16,
    parameter int unsigned      NUM_BANKS = 2,
    parameter logic [AW-1:0]    STACK_TOP = '0,
    parameter int unsigned      MAX_DEPTH = 256,
    localparam int unsigned     SW        = sel_width(NUM_BANKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] bank_sel,
    input  logic          push,
    input  logic          pop,
    input  logic          load,
    input  logic          adj_en,
    input  logic [AW-1:0] adj_val,
    input  logic [AW-1:0] sp_in,
    input  logic          fault_clr,
    output logic [AW-1:0] sp_out,
    output logic [AW-1:0] sp_q,
    output logic [AW-1:0] depth,
    output logic          op_err,
    output logic          overflow,
    output logic          underflow,
    output logic          fault,
    output logic [SW-1:0] fault_bank
);

    logic [AW-1:0] bank_q [NUM_BANKS];
    logic [AW-1:0] cur_sp;
    logic [AW-1:0] sp_next;
    logic          sel_valid;
    logic          ovf_raw;
    logic          unf_raw;
    logic          ovf_evt;
    logic          unf_evt;
    logic          is_checked;
    logic          in_fault;
    logic          sp_wr;
    op_e           op;

    state_e        state_q, state_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [SW-1:0] fault_bank_q, fault_bank_d;

    // Non-power-of-two bank counts leave unused select codes; those act on no bank.
    assign sel_valid = (32'(bank_sel) < NUM_BANKS);

    always_comb begin
        cur_sp = STACK_TOP;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (sel_valid && (bank_sel == SW'(i))) begin
                cur_sp = bank_q[i];
            end
        end
    end

    always_comb begin
        op = OP_NONE;
        if (load && pop) begin
            op = OP_LOADPOP;
        end else if (push && pop) begin
            op = OP_HOLDPP;
        end else if (load) begin
            op = OP_LOAD;
        end else if (pop) begin
            op = OP_POP;
        end else if (push) begin
            op = OP_PUSH;
        end else if (adj_en) begin
            op = OP_ADJ;
        end
    end

    stack_bound_check #(
        .AW        (AW),
        .STACK_TOP (STACK_TOP),
        .MAX_DEPTH (MAX_DEPTH)
    ) u_bound_check (
        .sp      (cur_sp),
        .op      (op),
        .adj_val (adj_val),
        .sp_in   (sp_in),
        .sp_next (sp_next),
        .ovf_evt (ovf_raw),
        .unf_evt (unf_raw)
    );

    assign in_fault   = (state_q == FAULT);
    assign is_checked = (op == OP_POP) || (op == OP_PUSH) || (op == OP_ADJ);

    // Events only exist in RUN; in FAULT the checked rules are suppressed entirely.
    assign ovf_evt = sel_valid && !in_fault && ovf_raw;
    assign unf_evt = sel_valid && !in_fault && unf_raw;
    assign op_err  = sel_valid && is_checked && (ovf_raw || unf_raw || in_fault);

    // sp_next already equals cur_sp when an event holds the SP.
    assign sp_wr = sel_valid && !(is_checked && in_fault);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i] <= STACK_TOP;
            end
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (sp_wr && (bank_sel == SW'(i))) begin
                    bank_q[i] <= sp_next;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        fault_bank_d = fault_bank_q;
        case (state_q)
            RUN: begin
                if (fault_clr) begin
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                end
                // A new event beats a simultaneous fault_clr.
                if (ovf_evt || unf_evt) begin
                    state_d      = FAULT;
                    fault_bank_d = bank_sel;
                    if (ovf_evt) begin
                        overflow_d = 1'b1;
                    end
                    if (unf_evt) begin
                        underflow_d = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d     = RUN;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            fault_bank_q <= '0;
        end else begin
            state_q      <= state_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            fault_bank_q <= fault_bank_d;
        end
    end

    always_comb begin
        if (push) begin
            sp_out = cur_sp - 1'b1;
        end else if (load) begin
            sp_out = sp_in;
        end else begin
            sp_out = cur_sp;
        end
    end

    assign sp_q       = cur_sp;
    assign depth      = STACK_TOP - cur_sp;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign fault      = in_fault;
    assign fault_bank = fault_bank_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit: a default instance (MAX_DEPTH=256) and a
// shallow instance (MAX_DEPTH=4) share one stimulus stream.
module tb_stack_pointer_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  bank_sel;
    logic        push, pop, load, adj_en, fault_clr;
    logic [15:0] adj_val, sp_in;

    logic [15:0] sp_out, sp_q, depth;
    logic        op_err, overflow, underflow, fault;
    logic [0:0]  fault_bank;

    logic [15:0] sp_out4, sp_q4, depth4;
    logic        op_err4, overflow4, underflow4, fault4;
    logic [0:0]  fault_bank4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_pointer_unit #(
        .AW(16), .NUM_BANKS(2), .STACK_TOP(16'h0000), .MAX_DEPTH(256)
    ) dut (
        .clk(clk), .rst(rst), .bank_sel(bank_sel), .push(push), .pop(pop), .load(load),
        .adj_en(adj_en), .adj_val(adj_val), .sp_in(sp_in), .fault_clr(fault_clr),
        .sp_out(sp_out), .sp_q(sp_q), .depth(depth), .op_err(op_err),
        .overflow(overflow), .underflow(underflow), .fault(fault), .fault_bank(fault_bank)
    );

    stack_pointer_unit #(
        .AW(16), .NUM_BANKS(2), .STACK_TOP(16'h0000), .MAX_DEPTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .bank_sel(bank_sel), .push(push), .pop(pop), .load(load),
        .adj_en(adj_en), .adj_val(adj_val), .sp_in(sp_in), .fault_clr(fault_clr),
        .sp_out(sp_out4), .sp_q(sp_q4), .depth(depth4), .op_err(op_err4),
        .overflow(overflow4), .underflow(underflow4), .fault(fault4),
        .fault_bank(fault_bank4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 0; pop = 0; load = 0; adj_en = 0; fault_clr = 0;
    endtask

    task automatic clear_fault();
        fault_clr = 1;
        step();
        fault_clr = 0;
    endtask

    initial begin
        rst = 1; bank_sel = 0; adj_val = 0; sp_in = 0;
        idle();
        #12;
        chk("rst_sp_q", 32'(sp_q), 32'h0000);
        chk("rst_depth", 32'(depth), 32'h0000);
        chk("rst_flags", {29'd0, overflow, underflow, fault}, 32'h0);
        chk("rst_fault_bank", 32'(fault_bank), 32'h0);
        chk("rst_sp_q4", 32'(sp_q4), 32'h0000);
        rst = 0;

        // push x3 on bank0
        push = 1; #1;
        chk("push1_sp_out", 32'(sp_out), 32'hFFFF);
        step();
        chk("push2_sp_out", 32'(sp_out), 32'hFFFE);
        chk("push1_sp_q", 32'(sp_q), 32'hFFFF);
        step();
        chk("push3_sp_out", 32'(sp_out), 32'hFFFD);
        step();
        push = 0; #1;
        chk("push3_sp_q", 32'(sp_q), 32'hFFFD);
        chk("push3_depth", 32'(depth), 32'h0003);

        // pop x3 back to empty
        pop = 1; #1;
        chk("pop_op_err", 32'(op_err), 32'h0);
        repeat (3) step();
        pop = 0; #1;
        chk("pop3_sp_q", 32'(sp_q), 32'h0000);
        chk("pop3_depth", 32'(depth), 32'h0000);
        chk("pop3_flags", {29'd0, overflow, underflow, fault}, 32'h0);

        // pop at empty -> underflow
        pop = 1; #1;
        chk("unf_op_err", 32'(op_err), 32'h1);
        chk("unf_sp_out", 32'(sp_out), 32'h0000);
        step();
        pop = 0; #1;
        chk("unf_flag", 32'(underflow), 32'h1);
        chk("unf_ovf_flag", 32'(overflow), 32'h0);
        chk("unf_fault", 32'(fault), 32'h1);
        chk("unf_fault_bank", 32'(fault_bank), 32'h0);
        chk("unf_sp_q", 32'(sp_q), 32'h0000);

        // push while in FAULT is suppressed
        push = 1; #1;
        chk("fpush_op_err", 32'(op_err), 32'h1);
        chk("fpush_sp_out", 32'(sp_out), 32'hFFFF);
        step();
        push = 0; #1;
        chk("fpush_sp_q", 32'(sp_q), 32'h0000);
        chk("fpush_fault", 32'(fault), 32'h1);
        clear_fault(); #1;
        chk("clr_fault", 32'(fault), 32'h0);
        chk("clr_unf", 32'(underflow), 32'h0);

        // MAX_DEPTH=4 instance: fifth push overflows even with fault_clr asserted
        push = 1;
        repeat (4) step();
        chk("max_sp_q4", 32'(sp_q4), 32'hFFFC);
        chk("max_depth4", 32'(depth4), 32'h0004);
        chk("max_op_err4", 32'(op_err4), 32'h1);
        chk("max_op_err256", 32'(op_err), 32'h0);
        fault_clr = 1;
        step();
        push = 0; fault_clr = 0; #1;
        chk("max_ovf4", 32'(overflow4), 32'h1);
        chk("max_unf4", 32'(underflow4), 32'h0);
        chk("max_fault4", 32'(fault4), 32'h1);
        chk("max_hold4", 32'(sp_q4), 32'hFFFC);
        chk("max_sp_q256", 32'(sp_q), 32'hFFFB);
        chk("max_fault256", 32'(fault), 32'h0);
        clear_fault(); #1;
        chk("max_clr4", {30'd0, overflow4, fault4}, 32'h0);

        // simultaneous operations
        load = 1; sp_in = 16'h0010;
        step();
        load = 0; #1;
        chk("ld_sp_q", 32'(sp_q), 32'h0010);
        load = 1; pop = 1; sp_in = 16'h0100; #1;
        chk("ldpop_sp_out", 32'(sp_out), 32'h0100);
        step();
        idle(); #1;
        chk("ldpop_sp_q", 32'(sp_q), 32'h0101);
        push = 1; pop = 1; #1;
        chk("pp_sp_out", 32'(sp_out), 32'h0100);
        chk("pp_op_err", 32'(op_err), 32'h0);
        step();
        idle(); #1;
        chk("pp_sp_q", 32'(sp_q), 32'h0101);
        load = 1; push = 1; pop = 1; sp_in = 16'h0200; #1;
        chk("lpp_sp_out", 32'(sp_out), 32'h0100);
        step();
        idle(); #1;
        chk("lpp_sp_q", 32'(sp_q), 32'h0201);

        // frame adjust
        load = 1; sp_in = 16'hFFF0;
        step();
        load = 0; #1;
        chk("adj_d16", 32'(depth), 32'h0010);
        adj_en = 1; adj_val = 16'hFFF8; #1;
        chk("adj_m8_op_err", 32'(op_err), 32'h0);
        chk("adj_sp_out", 32'(sp_out), 32'hFFF0);
        step();
        adj_en = 0; #1;
        chk("adj_m8_sp_q", 32'(sp_q), 32'hFFE8);
        chk("adj_m8_depth", 32'(depth), 32'h0018);
        adj_en = 1; adj_val = 16'h0020; #1;
        chk("adj_p32_op_err", 32'(op_err), 32'h1);
        step();
        adj_en = 0; #1;
        chk("adj_p32_unf", 32'(underflow), 32'h1);
        chk("adj_p32_ovf", 32'(overflow), 32'h0);
        chk("adj_p32_fault", 32'(fault), 32'h1);
        chk("adj_p32_hold", 32'(sp_q), 32'hFFE8);
        clear_fault();

        // adjust exactly to full, then push overflows
        load = 1; sp_in = 16'hFF06;
        step();
        load = 0; adj_en = 1; adj_val = 16'hFFFA; #1;
        chk("adj_full_op_err", 32'(op_err), 32'h0);
        step();
        adj_en = 0; #1;
        chk("adj_full_sp_q", 32'(sp_q), 32'hFF00);
        chk("adj_full_depth", 32'(depth), 32'h0100);
        push = 1; #1;
        chk("full_push_op_err", 32'(op_err), 32'h1);
        step();
        push = 0; #1;
        chk("full_push_ovf", 32'(overflow), 32'h1);
        chk("full_push_hold", 32'(sp_q), 32'hFF00);
        clear_fault();

        // d=250, adjust -10 -> overflow
        load = 1; sp_in = 16'hFF06;
        step();
        load = 0; adj_en = 1; adj_val = 16'hFFF6; #1;
        chk("adj_m10_op_err", 32'(op_err), 32'h1);
        step();
        adj_en = 0; #1;
        chk("adj_m10_ovf", 32'(overflow), 32'h1);
        chk("adj_m10_unf", 32'(underflow), 32'h0);
        chk("adj_m10_fault", 32'(fault), 32'h1);
        chk("adj_m10_hold", 32'(sp_q), 32'hFF06);
        clear_fault();

        // bank independence
        load = 1; sp_in = 16'hFFFF;
        step();
        load = 0; bank_sel = 1; #1;
        chk("bank1_init", 32'(sp_q), 32'h0000);
        push = 1;
        repeat (2) step();
        push = 0; #1;
        chk("bank1_sp_q", 32'(sp_q), 32'hFFFE);
        chk("bank1_depth", 32'(depth), 32'h0002);
        bank_sel = 0; #1;
        chk("bank0_sp_q", 32'(sp_q), 32'hFFFF);
        chk("bank0_depth", 32'(depth), 32'h0001);

        // underflow on bank1 records the faulting bank
        bank_sel = 1; pop = 1;
        repeat (2) step();
        chk("bank1_unf_op_err", 32'(op_err), 32'h1);
        step();
        pop = 0; #1;
        chk("bank1_fault", 32'(fault), 32'h1);
        chk("bank1_unf", 32'(underflow), 32'h1);
        chk("bank1_fault_bank", 32'(fault_bank), 32'h1);

        // asynchronous reset mid-cycle
        push = 1; rst = 1; #1;
        chk("arst_fault", 32'(fault), 32'h0);
        chk("arst_unf", 32'(underflow), 32'h0);
        chk("arst_fault_bank", 32'(fault_bank), 32'h0);
        bank_sel = 0; #1;
        chk("arst_bank0", 32'(sp_q), 32'h0000);
        chk("arst_bank0_4", 32'(sp_q4), 32'h0000);
        idle(); rst = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
